// File: rtl/data_mem_be_pkg.sv
// Shared types and constants for the byte-enabled data memory.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    localparam logic [31:0] MEM_ERR_DATA = 32'hFA11_1EAF;

endpackage

// File: rtl/data_mem_be_be_ram.sv
// Word-organised storage with per-byte write lanes and a registered read port.
module be_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic                           en,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (be[k]) begin
                        mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_be.sv
// Load/store data memory: request capture, fixed access latency, range/alignment
// checking and a one-cycle completion pulse.
module data_mem_be
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic        ready_o,
    output logic        err_o,
    output logic [31:0] read_data_o
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAT4     = 4'(LATENCY);
    localparam bit          ZERO_LAT = (LATENCY == 0);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;
    logic        err_q, load_q;
    logic [31:0] data_q;

    logic        accept, fire;
    logic        acc_we, acc_err;
    logic [3:0]  acc_be;
    logic [31:0] acc_addr, acc_wdata;
    logic [AW-1:0] ram_addr;
    logic        ram_en;
    logic [31:0] ram_rdata;
    logic [31:0] rdata_mux;

    // With zero latency the access happens on the accepting edge, so the RAM
    // is driven straight from the inputs; otherwise from the capture registers.
    always_comb begin
        accept    = (state_q == IDLE) && mem_req_i;
        fire      = (accept && ZERO_LAT) || ((state_q == WAIT) && (cnt_q == 4'd1));
        acc_addr  = (state_q == IDLE) ? addr_i         : addr_q;
        acc_we    = (state_q == IDLE) ? write_enable_i : we_q;
        acc_be    = (state_q == IDLE) ? byte_enable_i  : be_q;
        acc_wdata = (state_q == IDLE) ? write_data_i   : wdata_q;
        acc_err   = (acc_addr[1:0] != 2'b00)
                 || ({1'b0, acc_addr} < {1'b0, BASE_ADDR})
                 || ({1'b0, acc_addr} >= END_ADDR);
        ram_addr  = AW'((acc_addr - BASE_ADDR) >> 2);
        ram_en    = fire && !acc_err;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mem_req_i) state_d = ZERO_LAT ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= write_enable_i;
                be_q    <= byte_enable_i;
                addr_q  <= addr_i;
                wdata_q <= write_data_i;
                cnt_q   <= LAT4;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (fire) begin
                err_q  <= acc_err;
                load_q <= !acc_we && !acc_err;
            end
            if (state_q == RESP) begin
                data_q <= rdata_mux;
            end
        end
    end

    be_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i (clk_i),
        .en    (ram_en),
        .we    (acc_we),
        .be    (acc_be),
        .addr  (ram_addr),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // The RAM read lands during RESP; data_q holds it afterwards.
    always_comb begin
        rdata_mux = data_q;
        if (state_q == RESP) begin
            if (err_q)       rdata_mux = MEM_ERR_DATA;
            else if (load_q) rdata_mux = ram_rdata;
        end
    end

    assign ready_o     = (state_q == RESP);
    assign err_o       = ready_o && err_q;
    assign read_data_o = rdata_mux;

endmodule

// File: tb/tb_data_mem_be.sv
// Randomised scoreboard bench for data_mem_be (LATENCY=2 main instance plus a
// LATENCY=0 instance for back-to-back behaviour).
module tb_data_mem_be;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] ERRD  = 32'hFA11_1EAF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wd = '0;
    logic        ready, err;
    logic [31:0] rd;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [3:0]  be0 = '0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic        ready0, err0;
    logic [31:0] rd0;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mdl [DEPTH];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_be #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wd),
        .ready_o(ready), .err_o(err), .read_data_o(rd)
    );

    data_mem_be #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req0), .write_enable_i(we0),
        .byte_enable_i(be0), .addr_i(addr0), .write_data_i(wd0),
        .ready_o(ready0), .err_o(err0), .read_data_o(rd0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned la = longint'(a);
        return (a % 4 != 0) || (la >= 4 * longint'(DEPTH));
    endfunction

    // Reference behaviour: decide the outcome, update the model, queue the expectation.
    task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   seen = 0;
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wd = d;
        e.cyc = cyc + 1 + LAT;
        if (addr_bad(a)) begin
            e.err = 1'b1;
            last_rd = ERRD;
        end else begin
            e.err = 1'b0;
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mdl[a/4][k*8 +: 8] = d[k*8 +: 8];
            end else begin
                last_rd = mdl[a/4];
            end
        end
        e.data = last_rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'($urandom); be = 4'($urandom); addr = $urandom; wd = $urandom;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ready) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL timeout: got no ready_o expected ready_o within 40 cycles");
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: got ready_o=1 expected ready_o=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("err_o", 32'(err), 32'(e.err));
                chk("read_data_o", rd, e.data);
            end
        end else begin
            chk("err_o_idle", 32'(err), 32'd0);
        end
    end

    task automatic op0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        @(negedge clk);
        req0 = 1'b1; we0 = w; be0 = 4'hF; addr0 = a; wd0 = d;
        @(posedge clk);
        #1;
        req0 = 1'b0; addr0 = $urandom; wd0 = $urandom;
        @(negedge clk);
        chk("l0_ready", 32'(ready0), 32'd1);
        chk("l0_err", 32'(err0), 32'd0);
        if (!w) chk("l0_read_data", rd0, exp_rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, held;
        int unsigned r;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_ready", 32'(ready), 32'd0);
            chk("reset_rdata", rd, 32'd0);
        end

        for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, 32'(i * 4), $urandom);

        issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 32'h10, $urandom);
        issue(1'b1, 4'b0101, 32'h10, 32'h11223344);
        issue(1'b0, 4'h0, 32'h10, $urandom);
        @(negedge clk);
        chk("partial_hold", rd, 32'hDE22BE44);
        issue(1'b0, 4'hF, 32'h13, $urandom);
        issue(1'b1, 4'hF, 32'h1000, 32'h0BAD_F00D);
        issue(1'b0, 4'h0, 32'h0, $urandom);
        issue(1'b1, 4'h0, 32'h0, 32'hFFFF_FFFF);
        issue(1'b0, 4'h0, 32'h0, $urandom);

        // Reset while a store to 0x20 is waiting; the store must be lost.
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h20; wd = ~mdl[8];
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_rdata", rd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        repeat (5) @(negedge clk);
        issue(1'b0, 4'h0, 32'h20, $urandom);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 1) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h1000 + 32'($urandom_range(0, 15) * 4);
                    1:       a = 32'hFFFF_FFFC;
                    default: a = 32'h8000_0000;
                endcase
            end else         a = 32'($urandom_range(0, 15) * 4);
            issue(1'($urandom), 4'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Zero-latency instance: preset words, then hold req for 8 cycles.
        for (int i = 0; i < 8; i++) op0(1'b1, 32'(i * 4), 32'hA5A5_0000 + 32'(i), '0);
        held = rd0;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            if (j > 0) begin
                chk("b2b_ready", 32'(ready0), ((j - 1) % 2 == 0) ? 32'd1 : 32'd0);
                chk("b2b_err", 32'(err0), 32'd0);
                chk("b2b_rdata_held", rd0, held);
            end
            if (j < 8) begin
                req0 = 1'b1; we0 = 1'b1; be0 = 4'hF;
                addr0 = 32'(j * 4); wd0 = 32'h1000_0000 + 32'(j);
            end else begin
                req0 = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++)
            op0(1'b0, 32'(i * 4), '0, (i % 2 == 0) ? 32'h1000_0000 + 32'(i) : 32'hA5A5_0000 + 32'(i));

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
